// File: rtl/wb_stage_buf.sv
// Writeback stage: DEPTH-entry in-order buffer between MEM and the register-file write port,
// with head forwarding, pending-write mask, retired-instruction counter and debug trace.
module wb_stage_buf #(
    parameter  int XLEN       = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int DEPTH      = 2,
    localparam int BUS_W      = REG_ADDR_W + 1 + 2 * XLEN,
    localparam int NREG       = 2 ** REG_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [BUS_W-1:0]               mem_wb_bus_in,
    input  logic                           ms_to_ws_valid,
    output logic                           ws_allowin,
    input  logic                           rf_wready,
    output logic                           rf_we,
    output logic [REG_ADDR_W-1:0]          rf_waddr,
    output logic [XLEN-1:0]                rf_wdata,
    output logic [REG_ADDR_W+XLEN:0]       wb_data_bus_out,
    output logic [NREG-1:0]                ws_pend_mask,
    output logic                           ws_empty,
    output logic [63:0]                    instret,
    output logic [XLEN-1:0]                debug_wb_pc,
    output logic [3:0]                     debug_wb_rf_wen,
    output logic [REG_ADDR_W-1:0]          debug_wb_rf_wnum,
    output logic [XLEN-1:0]                debug_wb_rf_wdata
);

    // A single-entry buffer keeps a 1-bit pointer that never leaves zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [REG_ADDR_W-1:0] slot_rd_q   [DEPTH];
    logic                  slot_wen_q  [DEPTH];
    logic [XLEN-1:0]       slot_data_q [DEPTH];
    logic [XLEN-1:0]       slot_pc_q   [DEPTH];
    logic [DEPTH-1:0]      slot_vld_q;

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [63:0]           instret_q, instret_d;

    logic                  push, pop, head_valid, head_eff;
    logic [REG_ADDR_W-1:0] in_rd, h_rd;
    logic                  in_wen, h_wen;
    logic [XLEN-1:0]       in_data, in_pc, h_data, h_pc;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_rd   = mem_wb_bus_in[BUS_W-1 -: REG_ADDR_W];
    assign in_wen  = mem_wb_bus_in[2*XLEN];
    assign in_data = mem_wb_bus_in[2*XLEN-1 -: XLEN];
    assign in_pc   = mem_wb_bus_in[XLEN-1:0];

    always_comb begin
        ws_allowin = (count_q != CNT_W'(DEPTH));
        head_valid = (count_q != '0);
        push       = ms_to_ws_valid & ws_allowin;
        pop        = head_valid & rf_wready;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        instret_d  = instret_q + 64'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            instret_q  <= '0;
            slot_vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_rd_q[i]   <= '0;
                slot_wen_q[i]  <= 1'b0;
                slot_data_q[i] <= '0;
                slot_pc_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            instret_q <= instret_d;
            // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
            if (push) begin
                slot_rd_q[wr_ptr_q]   <= in_rd;
                slot_wen_q[wr_ptr_q]  <= in_wen;
                slot_data_q[wr_ptr_q] <= in_data;
                slot_pc_q[wr_ptr_q]   <= in_pc;
                slot_vld_q[wr_ptr_q]  <= 1'b1;
            end
            if (pop) begin
                slot_vld_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    assign h_rd   = slot_rd_q[rd_ptr_q];
    assign h_wen  = slot_wen_q[rd_ptr_q];
    assign h_data = slot_data_q[rd_ptr_q];
    assign h_pc   = slot_pc_q[rd_ptr_q];

    always_comb begin
        head_eff        = head_valid & h_wen & (h_rd != '0);
        rf_we           = head_eff & rf_wready;
        rf_waddr        = head_valid ? h_rd   : '0;
        rf_wdata        = head_valid ? h_data : '0;
        wb_data_bus_out = head_valid ? {h_rd, head_eff, h_data} : '0;
        debug_wb_pc     = head_valid ? h_pc   : '0;
        ws_empty        = ~head_valid;
        instret         = instret_q;
    end

    always_comb begin
        ws_pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_vld_q[i] && slot_wen_q[i] && (slot_rd_q[i] != '0)) begin
                ws_pend_mask[slot_rd_q[i]] = 1'b1;
            end
        end
    end

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
